// File: rtl/chimera_pkg.sv
// Shared types and default constants for the Chimera cluster power controller.
package chimera_pkg;

  // Power sequencing states of one cluster domain.
  typedef enum logic [3:0] {
    OFF       = 4'd0,
    CLK_ON    = 4'd1,
    RST_REL   = 4'd2,
    ISO_REL   = 4'd3,
    ON        = 4'd4,
    DRAIN     = 4'd5,
    ISO_SET   = 4'd6,
    RST_SET   = 4'd7,
    CLK_OFF   = 4'd8,
    BYP_DRAIN = 4'd9
  } cluster_pwr_state_e;

  localparam int unsigned DefNumPorts        = 32'd3;
  localparam int unsigned DefCntWidth        = 32'd8;
  localparam int unsigned DefClkSettleCycles = 32'd4;
  localparam int unsigned DefRstHoldCycles   = 32'd8;
  localparam int unsigned DefDrainTimeout    = 32'd1024;

  // Wait timer width; settle, hold and drain-timeout values must fit below 2**16.
  localparam int unsigned TmrWidth = 32'd16;

endpackage

// File: rtl/chimera_txn_counter.sv
// Outstanding AXI transaction counter: +1 per AW/AR handshake, -1 per B and
// per R-last handshake, saturating at both ends with a sticky error flag.
module chimera_txn_counter import chimera_pkg::*; #(
  parameter int unsigned NumPorts = DefNumPorts,
  parameter int unsigned CntWidth = DefCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] aw_hs_i,
  input  logic [NumPorts-1:0] ar_hs_i,
  input  logic [NumPorts-1:0] b_hs_i,
  input  logic [NumPorts-1:0] r_last_hs_i,
  output logic                zero_o,  // count after this cycle's handshakes is zero
  output logic                err_o    // sticky under/overflow
);

  localparam int unsigned SumWidth = CntWidth + 32'd2;

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [SumWidth-1:0] sum_s;

  function automatic logic [SumWidth-1:0] popcnt(input logic [NumPorts-1:0] v);
    logic [SumWidth-1:0] c;
    c = {SumWidth{1'b0}};
    for (int i = 0; i < int'(NumPorts); i++) begin
      c = c + {{(SumWidth-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Two's-complement sum at CntWidth+2 bits, then clamp to [0, 2**CntWidth-1].
  always_comb begin
    sum_s = {2'b00, cnt_q} + popcnt(aw_hs_i) + popcnt(ar_hs_i)
            - popcnt(b_hs_i) - popcnt(r_last_hs_i);
    err_d = err_q;
    if (sum_s[SumWidth-1]) begin
      cnt_d = {CntWidth{1'b0}};
      err_d = 1'b1;
    end else if (|sum_s[SumWidth-2:CntWidth]) begin
      cnt_d = {CntWidth{1'b1}};
      err_d = 1'b1;
    end else begin
      cnt_d = sum_s[CntWidth-1:0];
    end
    zero_o = (cnt_d == {CntWidth{1'b0}});
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CntWidth{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/chimera_cluster_pwr_ctrl.sv
// Per-cluster power sequencer: clock, reset and isolation ordering on power
// up/down, AXI drain before power-down or wide-memory bypass switching.
module chimera_cluster_pwr_ctrl import chimera_pkg::*; #(
  parameter int unsigned NumPorts        = DefNumPorts,
  parameter int unsigned CntWidth        = DefCntWidth,
  parameter int unsigned ClkSettleCycles = DefClkSettleCycles,
  parameter int unsigned RstHoldCycles   = DefRstHoldCycles,
  parameter int unsigned DrainTimeout    = DefDrainTimeout,
  parameter logic        BypassRstVal    = 1'b0
) (
  input  logic                soc_clk_i,
  input  logic                rst_i,
  input  logic                pwr_req_i,
  input  logic                bypass_req_i,
  input  logic [NumPorts-1:0] aw_hs_i,
  input  logic [NumPorts-1:0] ar_hs_i,
  input  logic [NumPorts-1:0] b_hs_i,
  input  logic [NumPorts-1:0] r_last_hs_i,
  output logic                clk_en_o,
  output logic                clu_rst_no,
  output logic                iso_o,
  output logic                block_o,
  output logic                widemem_bypass_o,
  output logic                busy_o,
  output logic                on_o,
  output logic                timeout_o,
  output logic                err_o
);

  localparam logic [TmrWidth-1:0] ClkLoad   = TmrWidth'(ClkSettleCycles - 32'd1);
  localparam logic [TmrWidth-1:0] RstLoad   = TmrWidth'(RstHoldCycles - 32'd1);
  localparam logic [TmrWidth-1:0] DrainLast =
    TmrWidth'((DrainTimeout == 32'd0) ? 32'd0 : DrainTimeout - 32'd1);
  localparam bit                  DrainEn   = (DrainTimeout != 32'd0);
  localparam logic [TmrWidth-1:0] TmrZero   = {TmrWidth{1'b0}};
  localparam logic [TmrWidth-1:0] TmrOne    = TmrWidth'(32'd1);
  localparam logic [TmrWidth-1:0] TmrMax    = {TmrWidth{1'b1}};

  cluster_pwr_state_e  state_q, state_d;
  logic [TmrWidth-1:0] timer_q, timer_d;
  logic clk_en_q, clk_en_d, clu_rst_n_q, clu_rst_n_d, iso_q, iso_d;
  logic block_q, block_d, bypass_q, bypass_d, busy_q, busy_d, on_q, on_d;
  logic timeout_q, timeout_d;
  logic cnt_zero_s, byp_exit_s, drain_tick_s;

  chimera_txn_counter #(
    .NumPorts (NumPorts),
    .CntWidth (CntWidth)
  ) u_txn_counter (
    .clk_i       (soc_clk_i),
    .rst_i       (rst_i),
    .aw_hs_i     (aw_hs_i),
    .ar_hs_i     (ar_hs_i),
    .b_hs_i      (b_hs_i),
    .r_last_hs_i (r_last_hs_i),
    .zero_o      (cnt_zero_s),
    .err_o       (err_o)
  );

  // Next state, wait timer and sticky timeout; outputs decoded from the next
  // state so every output is a flop aligned with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bypass_d     = bypass_q;
    timeout_d    = timeout_q;
    byp_exit_s   = 1'b0;
    drain_tick_s = 1'b0;

    case (state_q)
      OFF: begin
        // No traffic can exist while off, so bypass follows the request directly.
        bypass_d = bypass_req_i;
        if (pwr_req_i) begin
          state_d = CLK_ON;
          timer_d = ClkLoad;
        end else begin
          state_d = OFF;
        end
      end
      CLK_ON: begin
        if (timer_q == TmrZero) begin
          state_d = RST_REL;
          timer_d = RstLoad;
        end else begin
          timer_d = timer_q - TmrOne;
        end
      end
      RST_REL: begin
        if (timer_q == TmrZero) begin
          state_d = ISO_REL;
        end else begin
          timer_d = timer_q - TmrOne;
        end
      end
      ISO_REL: state_d = ON;
      ON: begin
        if (!pwr_req_i) begin
          state_d = DRAIN;
          timer_d = TmrZero;
        end else if (bypass_req_i != bypass_q) begin
          state_d = BYP_DRAIN;
          timer_d = TmrZero;
        end else begin
          state_d = ON;
        end
      end
      DRAIN: begin
        if (cnt_zero_s) begin
          state_d = ISO_SET;
        end else begin
          drain_tick_s = 1'b1;
        end
      end
      BYP_DRAIN: begin
        if (cnt_zero_s) begin
          state_d    = ON;
          bypass_d   = ~bypass_q;
          byp_exit_s = 1'b1;
        end else begin
          drain_tick_s = 1'b1;
        end
      end
      ISO_SET: state_d = RST_SET;
      RST_SET: state_d = CLK_OFF;
      CLK_OFF: state_d = OFF;
      default: state_d = OFF;
    endcase

    // Drain watchdog only flags; the sequencer keeps waiting for the ports.
    if (drain_tick_s) begin
      if (DrainEn && (timer_q == DrainLast)) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
      if (timer_q != TmrMax) begin
        timer_d = timer_q + TmrOne;
      end else begin
        timer_d = timer_q;
      end
    end else begin
      timeout_d = timeout_d;
    end

    {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b0011;
    case (state_d)
      OFF:              {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b0011;
      CLK_ON:           {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b1011;
      RST_REL:          {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b1111;
      ISO_REL:          {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b1101;
      // After a bypass switch, keep traffic blocked one more cycle so the new
      // mode is settled at the adapter before requests resume.
      ON:               {clk_en_d, clu_rst_n_d, iso_d, block_d} = {3'b110, byp_exit_s};
      DRAIN, BYP_DRAIN: {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b1101;
      ISO_SET:          {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b1111;
      RST_SET:          {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b1011;
      CLK_OFF:          {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b0011;
      default:          {clk_en_d, clu_rst_n_d, iso_d, block_d} = 4'b0011;
    endcase
    busy_d = (state_d != OFF) && (state_d != ON);
    on_d   = (state_d == ON);
  end

  // State, timer and registered outputs; rst_i wins over everything.
  always_ff @(posedge soc_clk_i) begin
    if (rst_i) begin
      state_q     <= OFF;
      timer_q     <= TmrZero;
      clk_en_q    <= 1'b0;
      clu_rst_n_q <= 1'b0;
      iso_q       <= 1'b1;
      block_q     <= 1'b1;
      bypass_q    <= BypassRstVal;
      busy_q      <= 1'b0;
      on_q        <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      clk_en_q    <= clk_en_d;
      clu_rst_n_q <= clu_rst_n_d;
      iso_q       <= iso_d;
      block_q     <= block_d;
      bypass_q    <= bypass_d;
      busy_q      <= busy_d;
      on_q        <= on_d;
      timeout_q   <= timeout_d;
    end
  end

  assign clk_en_o         = clk_en_q;
  assign clu_rst_no       = clu_rst_n_q;
  assign iso_o            = iso_q;
  assign block_o          = block_q;
  assign widemem_bypass_o = bypass_q;
  assign busy_o           = busy_q;
  assign on_o             = on_q;
  assign timeout_o        = timeout_q;

endmodule

// File: doc/chimera_cluster_pwr_ctrl.md
Name: chimera_cluster_pwr_ctrl

Overview:
Per-cluster sequencer that brings one Snitch cluster domain up and down and switches its wide-memory bypass mode safely.
It drives the cluster clock enable, cluster reset, domain isolation and an AXI issue-block gate.
It tracks outstanding AXI transactions across the cluster's master ports, so power-down and bypass switching happen only when the ports are drained.
One instance per cluster, in the SoC clock domain, beside the cluster adapter.

Parameters:
NumPorts, 3, number of monitored AXI master ports (2 narrow + 1 wide)
CntWidth, 8, outstanding-transaction counter width
ClkSettleCycles, 4, cycles the clock runs with reset held before reset release (>=1)
RstHoldCycles, 8, cycles between reset release and isolation release (>=1)
DrainTimeout, 1024, drain cycles before timeout flag (0 = disabled)
BypassRstVal, 1'b0, reset value of widemem_bypass_o

Ports:
soc_clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
pwr_req_i  in  1  level: 1 = cluster on requested
bypass_req_i  in  1  level: requested wide-memory bypass mode
aw_hs_i  in  NumPorts  AW handshake pulse per port
ar_hs_i  in  NumPorts  AR handshake pulse per port
b_hs_i  in  NumPorts  B handshake pulse per port
r_last_hs_i  in  NumPorts  R handshake with last=1, per port
clk_en_o  out  1  cluster clock-gate enable
clu_rst_no  out  1  cluster reset, active-low
iso_o  out  1  isolation enable for the cluster domain
block_o  out  1  suppress new AW/AR valid toward the SoC
widemem_bypass_o  out  1  bypass mode to the cluster adapter
busy_o  out  1  FSM in a transitional state
on_o  out  1  FSM in ON
timeout_o  out  1  sticky: a drain exceeded DrainTimeout
err_o  out  1  sticky: counter underflow or overflow

Behaviour:
- Interface (already decided): one clock, soc_clk_i; reset rst_i is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state OFF
  - clk_en_o=0, clu_rst_no=0, iso_o=1, block_o=1
  - widemem_bypass_o=BypassRstVal
  - busy_o=0, on_o=0, timeout_o=0, err_o=0
  - counter=0, wait timer=0
- Counter:
  - Each cycle: cnt += popcount(aw_hs_i|ar_hs_i bits, counting AW and AR separately) - popcount(b_hs_i) - popcount(r_last_hs_i).
  - Computed at CntWidth+2 signed width.
  - Result <0: saturate to 0, set err_o.
  - Result >2^CntWidth-1: saturate to max, set err_o.
  - Handshakes occurring in the same cycle block_o rises are still counted.
- OFF: clk_en=0, rst_n=0, iso=1, block=1. pwr_req_i=1 -> CLK_ON, load timer.
- CLK_ON: clk_en=1. Stay ClkSettleCycles cycles -> RST_REL.
- RST_REL: rst_n=1. Stay RstHoldCycles cycles -> ISO_REL.
- ISO_REL: iso=0. One cycle -> ON.
- ON: block=0, on_o=1. Priority order:
  - pwr_req_i=0 -> DRAIN.
  - else bypass_req_i != widemem_bypass_o -> BYP_DRAIN.
- DRAIN: block=1.
  - When cnt==0 -> ISO_SET.
  - Timer counts drain cycles; reaching DrainTimeout sets timeout_o. The FSM keeps waiting; no forced power-down.
- ISO_SET: iso=1, one cycle -> RST_SET.
- RST_SET: rst_n=0, one cycle -> CLK_OFF.
- CLK_OFF: clk_en=0, one cycle -> OFF.
- BYP_DRAIN: block=1, same timeout rule as DRAIN.
  - When cnt==0: toggle widemem_bypass_o (registered), -> ON.
  - block_o deasserts the cycle after ON is entered.
- Request sampling:
  - pwr_req_i and bypass_req_i are sampled only in OFF and ON.
  - Changes during transitional states are ignored until a stable state is reached. A drop of pwr_req_i during power-up completes to ON, then goes to DRAIN next cycle.
- busy_o=1 in every state except OFF and ON.
- Bypass requests in OFF: widemem_bypass_o updates directly, since no traffic is possible.
- timeout_o and err_o clear only on rst_i.
- rst_i mid-sequence: immediate return to reset values on the next edge, regardless of state or counter.

Decomposition:
- chimera_pkg:
  - cluster_pwr_state_e enum: OFF, CLK_ON, RST_REL, ISO_REL, ON, DRAIN, ISO_SET, RST_SET, CLK_OFF, BYP_DRAIN
  - default cycle constants
- Sub-module chimera_txn_counter: popcount-based up/down saturating counter with zero_o and err_o, parameterised by NumPorts and CntWidth.

Test Plan:
- Power-up: reset, pwr_req_i=1 at cycle 0 -> clk_en_o=1 at cycle 1, clu_rst_no=1 at cycle 5, iso_o=0 at cycle 13, on_o=1 and block_o=0 at cycle 14; busy_o=1 over cycles 1-13.
- Drained power-down: from ON with 3 AW + 2 AR outstanding, drop pwr_req_i.
  - block_o=1 next cycle; FSM holds DRAIN.
  - Return 3 B + 2 R-last over 5 cycles -> iso_o=1, then clu_rst_no=0, then clk_en_o=0 on consecutive cycles; OFF reached.
- Bypass switch: in ON with 1 read outstanding, bypass_req_i 0->1.
  - block_o=1 and widemem_bypass_o held at 0 until R-last.
  - widemem_bypass_o=1 the cycle R-last is counted to zero; block_o=0 one cycle later.
- Simultaneous events and underflow:
  - aw_hs_i=3'b101 with b_hs_i=3'b011 in one cycle -> cnt unchanged.
  - b_hs_i=1 with cnt=0 -> cnt stays 0, err_o=1 sticky.
- Timeout: DrainTimeout=16, no responses -> timeout_o=1 after 16 DRAIN cycles; FSM still in DRAIN; completes normally once responses arrive.
- Reset mid-sequence: rst_i asserted in RST_REL -> next cycle all outputs at reset values, cnt=0, state OFF.
